// File: rtl/sw_fifo_rd.sv
// Fabric-to-software capture FIFO with a Wishbone slave read-out port.
// Fabric pushes 32-bit words; software pops one word per DATA read and manages enable/flush/stickies.
module sw_fifo_rd #(
    parameter logic [31:0] C_BASEADDR        = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR        = 32'h0000_000F,
    parameter int          C_WB_DATA_WIDTH   = 32,
    parameter int          C_FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [3:0]                 wb_sel_i,
    input  logic [31:0]                wb_adr_i,
    input  logic [C_WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic [C_WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    input  logic [C_WB_DATA_WIDTH-1:0] fabric_data_in,
    input  logic                       fabric_valid_in,
    output logic                       fabric_ready_out,
    output logic                       fabric_overflow_out
);

    localparam int DW    = C_WB_DATA_WIDTH;
    localparam int AW    = C_FIFO_DEPTH_LOG2;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   SPAN     = C_HIGHADDR - C_BASEADDR;

    logic [DW-1:0] mem_q [DEPTH];

    logic          ack_q,      ack_d;
    logic [DW-1:0] dat_q,      dat_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          enable_q,   enable_d;
    logic          ovf_q,      ovf_d;
    logic          und_q,      und_d;
    logic [31:0]   drop_cnt_q, drop_cnt_d;

    logic req, hit, rd_data, wr_ctrl, flush, clr;
    logic empty, full, ready, push, pop, drop;
    logic [DW-1:0] status_w;

    // Bits never decoded; kept referenced so lint stays quiet.
    logic unused_ok;
    assign unused_ok = ^{wb_sel_i[3:1], wb_dat_i[DW-1:3]};

    // Subtracting the base makes one unsigned compare cover both range bounds.
    assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign hit     = req & ((wb_adr_i - C_BASEADDR) <= SPAN);
    assign rd_data = hit & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign wr_ctrl = hit & wb_we_i & (wb_adr_i[3:2] == 2'd2) & wb_sel_i[0];
    assign flush   = wr_ctrl & wb_dat_i[1];
    assign clr     = wr_ctrl & wb_dat_i[2];

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign ready = enable_q & ~full;
    assign pop   = rd_data & ~empty;
    assign push  = fabric_valid_in & ready & ~flush;
    assign drop  = fabric_valid_in & enable_q & full;

    assign status_w = DW'({12'd0, und_q, ovf_q, full, empty, {(16 - CW){1'b0}}, count_q});

    always_comb begin
        ack_d = req;
        dat_d = '0;
        if (hit && !wb_we_i) begin
            case (wb_adr_i[3:2])
                2'd0:    dat_d = empty ? '0 : mem_q[rd_ptr_q];
                2'd1:    dat_d = status_w;
                2'd2:    dat_d = {{(DW - 1){1'b0}}, enable_q};
                default: dat_d = DW'(drop_cnt_q);
            endcase
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        enable_d = wr_ctrl ? wb_dat_i[0] : enable_q;

        // Clear is applied first so a coincident drop still lands.
        ovf_d      = (clr ? 1'b0 : ovf_q) | drop;
        und_d      = (clr ? 1'b0 : und_q) | (rd_data & empty);
        drop_cnt_d = clr ? 32'd0 : drop_cnt_q;
        if (drop && drop_cnt_d != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_d + 32'd1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            enable_q   <= 1'b0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            enable_q   <= enable_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= fabric_data_in;
    end

    assign wb_ack_o            = ack_q;
    assign wb_dat_o            = dat_q;
    assign wb_err_o            = 1'b0;
    assign fabric_ready_out    = ready;
    assign fabric_overflow_out = ovf_q;

endmodule

// File: tb/tb_sw_fifo_rd.sv
// Directed bench for sw_fifo_rd: register access, FIFO ordering, overflow/underflow, flush and reset.
module tb_sw_fifo_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic [31:0] dat_o;
    logic        ack, err;
    logic [31:0] fdata;
    logic        fvalid;
    logic        fready, fovf;

    int checks   = 0;
    int failures = 0;

    sw_fifo_rd dut (
        .wb_clk_i            (clk),
        .wb_rst_n_i          (rst_n),
        .wb_cyc_i            (cyc),
        .wb_stb_i            (stb),
        .wb_we_i             (we),
        .wb_sel_i            (sel),
        .wb_adr_i            (adr),
        .wb_dat_i            (dat_i),
        .wb_dat_o            (dat_o),
        .wb_ack_o            (ack),
        .wb_err_o            (err),
        .fabric_data_in      (fdata),
        .fabric_valid_in     (fvalid),
        .fabric_ready_out    (fready),
        .fabric_overflow_out (fovf)
    );

    always #5 clk = ~clk;

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic ak);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        @(posedge clk);
        #1;
        ak = ack;
        rd = dat_o;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd, output logic ak);
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd, ak);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic ak);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy, ak);
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clk);
        fvalid = 1'b1; fdata = d;
        @(negedge clk);
        fvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic a;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0)   begin failures++; $display("FAIL rst_ack got=%b exp=0", ack); end
        checks++; if (dat_o !== 32'd0) begin failures++; $display("FAIL rst_dat got=%h exp=0", dat_o); end
        checks++; if (fready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", fready); end
        checks++; if (fovf !== 1'b0)   begin failures++; $display("FAIL rst_ovf got=%b exp=0", fovf); end
        @(negedge clk); rst_n = 1'b1;
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0001_0000) begin failures++; $display("FAIL rst_status got=%h exp=00010000", r); end
        wb_read(32'h8, r, a);
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", r); end
        wb_read(32'hC, r, a);
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL rst_drop got=%h exp=0", r); end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic a;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hA1; exp_w[1] = 32'hA2; exp_w[2] = 32'hA3;
        wb_write(32'h8, 32'h1, 4'hF, a);
        checks++; if (fready !== 1'b1) begin failures++; $display("FAIL t1_ready got=%b exp=1", fready); end
        for (int i = 0; i < 3; i++) push_word(exp_w[i]);
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0000_0003) begin failures++; $display("FAIL t1_status got=%h exp=00000003", r); end
        for (int i = 0; i < 3; i++) begin
            wb_read(32'h0, r, a);
            checks++; if (r !== exp_w[i]) begin failures++; $display("FAIL t1_data%0d got=%h exp=%h", i, r, exp_w[i]); end
        end
        wb_read(32'h0, r, a);
        checks++; if (a !== 1'b1 || r !== 32'd0) begin failures++; $display("FAIL t1_empty_rd got=%b/%h exp=1/0", a, r); end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t1_ack_pulse got=%b exp=0", ack); end
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0009_0000) begin failures++; $display("FAIL t1_underflow got=%h exp=00090000", r); end
        wb_write(32'h8, 32'h5, 4'hF, a);
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0001_0000) begin failures++; $display("FAIL t1_clear got=%h exp=00010000", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic a;
        int bad;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); fvalid = 1'b1; fdata = i;
        end
        @(negedge clk);
        checks++; if (fready !== 1'b0) begin failures++; $display("FAIL t2_ready got=%b exp=0", fready); end
        fdata = 32'hDEAD;
        @(negedge clk); fdata = 32'hBEEF;
        @(negedge clk); fvalid = 1'b0;
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0006_0010) begin failures++; $display("FAIL t2_status got=%h exp=00060010", r); end
        wb_read(32'hC, r, a);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL t2_drop got=%h exp=2", r); end
        checks++; if (fovf !== 1'b1) begin failures++; $display("FAIL t2_ovf_out got=%b exp=1", fovf); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            wb_read(32'h0, r, a);
            if (r !== 32'(i)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL t2_order got=%0d_bad exp=0_bad", bad); end
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0005_0000) begin failures++; $display("FAIL t2_drained got=%h exp=00050000", r); end
        wb_write(32'h8, 32'h5, 4'hF, a);
        wb_read(32'hC, r, a);
        checks++; if (r !== 32'd0 || fovf !== 1'b0) begin failures++; $display("FAIL t2_clear got=%h/%b exp=0/0", r, fovf); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic a;
        int bad;
        for (int i = 0; i < 5; i++) push_word(32'h50 + 32'(i));
        @(negedge clk);
        fvalid = 1'b1; fdata = 32'h55;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        @(posedge clk); #1;
        r = dat_o;
        @(negedge clk);
        fvalid = 1'b0; cyc = 1'b0; stb = 1'b0;
        checks++; if (r !== 32'h50) begin failures++; $display("FAIL t3_simul_rd got=%h exp=50", r); end
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0000_0005) begin failures++; $display("FAIL t3_count got=%h exp=00000005", r); end
        bad = 0;
        for (int i = 1; i < 6; i++) begin
            wb_read(32'h0, r, a);
            if (r !== 32'h50 + 32'(i)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL t3_order got=%0d_bad exp=0_bad", bad); end
        @(negedge clk);
        fvalid = 1'b1; fdata = 32'h66;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        @(posedge clk); #1;
        r = dat_o;
        @(negedge clk);
        fvalid = 1'b0; cyc = 1'b0; stb = 1'b0;
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL t3_empty_simul got=%h exp=0", r); end
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0008_0001) begin failures++; $display("FAIL t3_empty_status got=%h exp=00080001", r); end
        wb_read(32'h0, r, a);
        checks++; if (r !== 32'h66) begin failures++; $display("FAIL t3_stored got=%h exp=66", r); end
        wb_write(32'h8, 32'h5, 4'hF, a);
    endtask

    task automatic test_flush();
        logic [31:0] r; logic a;
        for (int i = 0; i < 9; i++) push_word(32'h90 + 32'(i));
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0000_0009) begin failures++; $display("FAIL t4_count got=%h exp=00000009", r); end
        @(negedge clk);
        fvalid = 1'b1; fdata = 32'hFF;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; dat_i = 32'h3; sel = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        fvalid = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0001_0000) begin failures++; $display("FAIL t4_status got=%h exp=00010000", r); end
        wb_read(32'hC, r, a);
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL t4_drop got=%h exp=0", r); end
        wb_read(32'h8, r, a);
        checks++; if (r !== 32'd1 || fready !== 1'b1) begin failures++; $display("FAIL t4_enable got=%h/%b exp=1/1", r, fready); end
    endtask

    task automatic test_reset_midread();
        logic [31:0] r; logic a;
        for (int i = 0; i < 7; i++) push_word(32'h80 + 32'(i));
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1 || dat_o !== 32'h80) begin failures++; $display("FAIL t5_inflight got=%b/%h exp=1/80", ack, dat_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (ack !== 1'b0 || dat_o !== 32'd0) begin failures++; $display("FAIL t5_async got=%b/%h exp=0/0", ack, dat_o); end
        checks++; if (fready !== 1'b0) begin failures++; $display("FAIL t5_ready got=%b exp=0", fready); end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0001_0000) begin failures++; $display("FAIL t5_status got=%h exp=00010000", r); end
        wb_read(32'h8, r, a);
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL t5_enable got=%h exp=0", r); end
    endtask

    task automatic test_ctrl_sel();
        logic [31:0] r; logic a;
        push_word(32'h11);
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0001_0000) begin failures++; $display("FAIL t6_disabled_push got=%h exp=00010000", r); end
        wb_read(32'hC, r, a);
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL t6_disabled_drop got=%h exp=0", r); end
        wb_write(32'h8, 32'h1, 4'b1110, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL t6_sel_ack got=%b exp=1", a); end
        wb_read(32'h8, r, a);
        checks++; if (r !== 32'd0 || fready !== 1'b0) begin failures++; $display("FAIL t6_sel_enable got=%h/%b exp=0/0", r, fready); end
        wb_write(32'h8, 32'h1, 4'hF, a);
        push_word(32'h71);
        push_word(32'h72);
        wb_write(32'h4, 32'hFFFF_FFFF, 4'hF, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL t6_ro_ack got=%b exp=1", a); end
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0000_0002) begin failures++; $display("FAIL t6_ro_status got=%h exp=00000002", r); end
        wb_read(32'h14, r, a);
        checks++; if (a !== 1'b1 || r !== 32'd0) begin failures++; $display("FAIL t6_oor_rd got=%b/%h exp=1/0", a, r); end
        wb_read(32'h4, r, a);
        checks++; if (r !== 32'h0000_0002) begin failures++; $display("FAIL t6_oor_nopop got=%h exp=00000002", r); end
        wb_read(32'h0, r, a);
        checks++; if (r !== 32'h71) begin failures++; $display("FAIL t6_head got=%h exp=71", r); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL t6_err got=%b exp=0", err); end
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'd0; dat_i = 32'd0; fdata = 32'd0; fvalid = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_midread();
        test_ctrl_sel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
